// File: rtl/multicycle_stall_ctrl_pkg.sv
// Shared definitions for the multi-cycle stall controller.
//   - op_class encodings (CLS_*)
//   - FSM state encoding
//   - max4(): largest of four ints, used to size the shared counter
package multicycle_stall_ctrl_pkg;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_MUL  = 2'b01;
    localparam logic [1:0] CLS_DIV  = 2'b10;
    localparam logic [1:0] CLS_REM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/multicycle_stall_ctrl_counter.sv
// mc_down_counter: loadable down counter with zero flag.
//   i_load/i_load_val : load a new count (wins over decrement)
//   i_dec             : decrement by one; saturates at zero
//   o_zero            : count is zero
module mc_down_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/multicycle_stall_ctrl.sv
// Stall/sequencing controller for long-latency EX units (MUL/DIV/REM).
//   i_op_valid/i_op_class : instruction in EX and its class
//   i_flush               : kills any op in EX
//   i_unit_done           : unit completion strobe (variable-latency mode)
//   o_stall               : hold IF/ID/EX (combinational)
//   o_unit_start          : one-cycle start pulse, first BUSY cycle
//   o_unit_rstn           : unit reset, low while idle
//   o_busy_class          : latched class of the in-flight op
//   o_result_valid        : result may be written back (DONE, not flushed)
//   o_timeout_err         : watchdog expired (variable-latency mode)
module multicycle_stall_ctrl
    import multicycle_stall_ctrl_pkg::*;
#(
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 9,
    parameter int LAT_REM = 9,
    parameter int VAR_LAT = 0,
    parameter int TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_op_valid,
    input  logic [1:0] i_op_class,
    input  logic       i_flush,
    input  logic       i_unit_done,
    output logic       o_stall,
    output logic       o_unit_start,
    output logic       o_unit_rstn,
    output logic [1:0] o_busy_class,
    output logic       o_result_valid,
    output logic       o_timeout_err
);

    localparam int MAX_LAT = max4(LAT_MUL, LAT_DIV, LAT_REM, 1);
    localparam int CW      = $clog2(max4(LAT_MUL, LAT_DIV, LAT_REM, TIMEOUT) + 1);

    if (LAT_MUL < 1 || LAT_DIV < 1 || LAT_REM < 1 ||
        (VAR_LAT != 0 && (TIMEOUT < 2 || TIMEOUT <= MAX_LAT))) begin : g_param_check
        $error("multicycle_stall_ctrl: illegal latency/timeout parameters");
    end

    state_e         r_state;
    logic           r_unit_start;
    logic           r_unit_rstn;
    logic [1:0]     r_busy_class;
    logic           r_timeout_err;

    logic           w_long;
    logic           w_accept;
    logic           w_zero;
    logic [CW-1:0]  w_load_val;

    assign w_long   = i_op_valid && (i_op_class != CLS_NONE);
    assign w_accept = (r_state == ST_IDLE) && w_long && !i_flush;

    // In variable mode the counter is only a watchdog.
    always_comb begin
        w_load_val = '0;
        if (VAR_LAT != 0)
            w_load_val = CW'(TIMEOUT - 1);
        else begin
            case (i_op_class)
                CLS_MUL: w_load_val = CW'(LAT_MUL - 1);
                CLS_DIV: w_load_val = CW'(LAT_DIV - 1);
                CLS_REM: w_load_val = CW'(LAT_REM - 1);
                default: w_load_val = '0;
            endcase
        end
    end

    mc_down_counter #(.W(CW)) u_cnt (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (r_state == ST_BUSY),
        .o_zero     (w_zero)
    );

    // Flush outranks unit_done, which outranks counter expiry.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= ST_IDLE;
            r_unit_start  <= 1'b0;
            r_unit_rstn   <= 1'b0;
            r_busy_class  <= CLS_NONE;
            r_timeout_err <= 1'b0;
        end else begin
            r_unit_start  <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_BUSY;
                        r_unit_start <= 1'b1;
                        r_unit_rstn  <= 1'b1;
                        r_busy_class <= i_op_class;
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        r_state      <= ST_IDLE;
                        r_unit_rstn  <= 1'b0;
                        r_busy_class <= CLS_NONE;
                    end else if ((VAR_LAT != 0) && i_unit_done) begin
                        r_state <= ST_DONE;
                    end else if (w_zero) begin
                        r_state       <= ST_DONE;
                        r_timeout_err <= (VAR_LAT != 0);
                    end
                end
                // The op still sitting in EX advances at this edge, so no
                // acceptance here.
                default: begin
                    r_state      <= ST_IDLE;
                    r_unit_rstn  <= 1'b0;
                    r_busy_class <= CLS_NONE;
                end
            endcase
        end
    end

    // Stall is gated by reset so a long op in EX cannot stall a reset pipe.
    assign o_stall        = i_resetn && ((r_state == ST_BUSY) ||
                                         ((r_state == ST_IDLE) && w_long && !i_flush));
    assign o_result_valid = (r_state == ST_DONE) && !i_flush;
    assign o_unit_start   = r_unit_start;
    assign o_unit_rstn    = r_unit_rstn;
    assign o_busy_class   = r_busy_class;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_multicycle_stall_ctrl.sv
module tb_multicycle_stall_ctrl;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // f = fixed-latency instance, v = variable-latency instance
    logic       f_ov, f_fl, f_ud, v_ov, v_fl, v_ud;
    logic [1:0] f_cls, v_cls;
    logic       f_st, f_sa, f_rn, f_rv, f_te, v_st, v_sa, v_rn, v_rv, v_te;
    logic [1:0] f_bc, v_bc;

    multicycle_stall_ctrl #(.VAR_LAT(0)) dut_f (
        .i_clk(clk), .i_resetn(resetn), .i_op_valid(f_ov), .i_op_class(f_cls),
        .i_flush(f_fl), .i_unit_done(f_ud), .o_stall(f_st), .o_unit_start(f_sa),
        .o_unit_rstn(f_rn), .o_busy_class(f_bc), .o_result_valid(f_rv),
        .o_timeout_err(f_te));

    multicycle_stall_ctrl #(.VAR_LAT(1), .TIMEOUT(64)) dut_v (
        .i_clk(clk), .i_resetn(resetn), .i_op_valid(v_ov), .i_op_class(v_cls),
        .i_flush(v_fl), .i_unit_done(v_ud), .o_stall(v_st), .o_unit_start(v_sa),
        .o_unit_rstn(v_rn), .o_busy_class(v_bc), .o_result_valid(v_rv),
        .o_timeout_err(v_te));

    typedef struct {
        bit         v;
        logic [6:0] e;
    } sb_t;

    sb_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc_no = 0;

    // {stall, start, rstn, busy_class, result_valid, timeout_err}
    function automatic logic [6:0] ex(input logic st, input logic sa, input logic rn,
                                      input logic [1:0] bc, input logic rv, input logic te);
        return {st, sa, rn, bc, rv, te};
    endfunction

    wire [6:0] out_f = {f_st, f_sa, f_rn, f_bc, f_rv, f_te};
    wire [6:0] out_v = {v_st, v_sa, v_rn, v_bc, v_rv, v_te};

    task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual(st,sa,rn,bc,rv,te)=%b required=%b", nm, cyc_no, act, req);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare both instances.
    sb_t ent;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ent = q.pop_front();
            if (ent.v) begin
                cmp("var_active", out_v, ent.e);
                cmp("fix_idle", out_f, 7'b0);
            end else begin
                cmp("fix_active", out_f, ent.e);
                cmp("var_idle", out_v, 7'b0);
            end
        end
    end

    // Drive one cycle on the selected instance (other held idle) and queue
    // the expected outputs for that cycle.
    task automatic cyc(input bit v, input logic ov, input logic [1:0] cls,
                       input logic fl, input logic ud, input logic [6:0] e);
        sb_t s;
        f_ov = v ? 1'b0 : ov;  f_cls = v ? 2'b0 : cls;
        f_fl = v ? 1'b0 : fl;  f_ud  = v ? 1'b0 : ud;
        v_ov = v ? ov : 1'b0;  v_cls = v ? cls : 2'b0;
        v_fl = v ? fl : 1'b0;  v_ud  = v ? ud : 1'b0;
        s.v = v; s.e = e;
        q.push_back(s);
        @(posedge clk); #1;
        cyc_no++;
    endtask

    localparam logic [6:0] Z = 7'b0;

    initial begin
        resetn = 1'b0;
        f_ov = 0; f_cls = 0; f_fl = 0; f_ud = 0;
        v_ov = 0; v_cls = 0; v_fl = 0; v_ud = 0;
        @(posedge clk); #1;

        // reset state, with a long op presented
        cyc(0, 1, 2'b10, 0, 0, Z);
        cyc(1, 1, 2'b11, 0, 0, Z);
        resetn = 1'b1;

        // A: fixed DIV held valid, class wiggles during BUSY
        cyc_no = 0;
        cyc(0, 1, 2'b10, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b10, 0, 0, ex(1,1,1,2'd2,0,0));
        for (int c = 2; c <= 9; c++)
            cyc(0, 1, (c >= 3 && c <= 5) ? 2'b11 : 2'b10, 0, 0, ex(1,0,1,2'd2,0,0));
        cyc(0, 1, 2'b10, 0, 0, ex(0,0,1,2'd2,1,0));
        cyc(0, 0, 2'b10, 0, 0, Z);
        cyc(0, 0, 2'b00, 0, 0, Z);

        // B: MUL then DIV back to back; unit_done ignored in fixed mode
        cyc_no = 0;
        cyc(0, 1, 2'b01, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b01, 0, 1, ex(1,1,1,2'd1,0,0));
        cyc(0, 1, 2'b01, 0, 0, ex(1,0,1,2'd1,0,0));
        cyc(0, 1, 2'b01, 0, 0, ex(0,0,1,2'd1,1,0));
        cyc(0, 1, 2'b10, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b10, 0, 0, ex(1,1,1,2'd2,0,0));
        for (int c = 6; c <= 13; c++)
            cyc(0, 1, 2'b10, 0, 0, ex(1,0,1,2'd2,0,0));
        cyc(0, 1, 2'b10, 0, 0, ex(0,0,1,2'd2,1,0));
        cyc(0, 0, 2'b00, 0, 0, Z);

        // C: flush in cycle 5 of a DIV
        cyc_no = 0;
        cyc(0, 1, 2'b10, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b10, 0, 0, ex(1,1,1,2'd2,0,0));
        for (int c = 2; c <= 4; c++)
            cyc(0, 1, 2'b10, 0, 0, ex(1,0,1,2'd2,0,0));
        cyc(0, 1, 2'b10, 1, 0, ex(1,0,1,2'd2,0,0));
        for (int c = 6; c <= 12; c++)
            cyc(0, 0, 2'b00, 0, 0, Z);

        // D: single-cycle op, flush with long op in IDLE, flush in DONE
        cyc_no = 0;
        cyc(0, 1, 2'b00, 0, 0, Z);
        cyc(0, 1, 2'b10, 1, 0, Z);
        cyc(0, 0, 2'b00, 0, 1, Z);
        cyc(0, 1, 2'b01, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b01, 0, 0, ex(1,1,1,2'd1,0,0));
        cyc(0, 1, 2'b01, 0, 0, ex(1,0,1,2'd1,0,0));
        cyc(0, 1, 2'b01, 1, 0, ex(0,0,1,2'd1,0,0));
        cyc(0, 0, 2'b00, 0, 0, Z);

        // E1: variable mode, unit_done in cycle 4
        cyc_no = 0;
        cyc(1, 1, 2'b01, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(1, 1, 2'b01, 0, 0, ex(1,1,1,2'd1,0,0));
        cyc(1, 1, 2'b01, 0, 0, ex(1,0,1,2'd1,0,0));
        cyc(1, 1, 2'b01, 0, 0, ex(1,0,1,2'd1,0,0));
        cyc(1, 1, 2'b01, 0, 1, ex(1,0,1,2'd1,0,0));
        cyc(1, 1, 2'b01, 0, 0, ex(0,0,1,2'd1,1,0));
        cyc(1, 0, 2'b00, 0, 1, Z);

        // E2: variable mode, no unit_done -> watchdog at cycle 65
        cyc_no = 0;
        cyc(1, 1, 2'b10, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(1, 1, 2'b10, 0, 0, ex(1,1,1,2'd2,0,0));
        for (int c = 2; c <= 64; c++)
            cyc(1, 1, 2'b10, 0, 0, ex(1,0,1,2'd2,0,0));
        cyc(1, 1, 2'b10, 0, 0, ex(0,0,1,2'd2,1,1));
        cyc(1, 0, 2'b00, 0, 0, Z);

        // E3: flush together with unit_done -> flush wins
        cyc_no = 0;
        cyc(1, 1, 2'b01, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(1, 1, 2'b01, 0, 0, ex(1,1,1,2'd1,0,0));
        cyc(1, 1, 2'b01, 1, 1, ex(1,0,1,2'd1,0,0));
        cyc(1, 0, 2'b00, 0, 0, Z);
        cyc(1, 0, 2'b00, 0, 0, Z);

        // F: async reset mid-BUSY of a REM, then a clean full-length REM
        cyc_no = 0;
        cyc(0, 1, 2'b11, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b11, 0, 0, ex(1,1,1,2'd3,0,0));
        cyc(0, 1, 2'b11, 0, 0, ex(1,0,1,2'd3,0,0));
        #2 resetn = 1'b0;
        #1 cmp("async_reset", out_f, Z);
        cyc(0, 1, 2'b11, 0, 0, Z);
        cyc(0, 1, 2'b11, 0, 0, Z);
        resetn = 1'b1;
        cyc_no = 0;
        cyc(0, 1, 2'b11, 0, 0, ex(1,0,0,2'd0,0,0));
        cyc(0, 1, 2'b11, 0, 0, ex(1,1,1,2'd3,0,0));
        for (int c = 2; c <= 9; c++)
            cyc(0, 1, 2'b11, 0, 0, ex(1,0,1,2'd3,0,0));
        cyc(0, 1, 2'b11, 0, 0, ex(0,0,1,2'd3,1,0));
        cyc(0, 0, 2'b00, 0, 0, Z);

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain actual=%0d pending required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_stall_ctrl.md
Name: multicycle_stall_ctrl

Overview:
Generalised stall/sequencing controller for long-latency execute-stage units (MUL, DIV, REM). It sits beside the ALU in EX and holds the front of the pipeline while a multi-cycle op runs. It drives the unit's start pulse and active-low reset, and signals result-valid for exactly one cycle. Per-class latencies are parameters; an optional variable-latency mode uses a done handshake with a timeout. A pipeline flush kills an in-flight op.

Parameters:
LAT_MUL, 2, fixed latency of MUL class in cycles (>=1)
LAT_DIV, 9, fixed latency of DIV class in cycles (>=1)
LAT_REM, 9, fixed latency of REM class in cycles (>=1)
VAR_LAT, 0, 0 = BUSY ends on counter; 1 = BUSY ends on unit_done, counter acts as timeout
TIMEOUT, 64, variable-mode watchdog in cycles (>=2, must exceed the largest LAT_*)

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  instruction in EX is valid
op_class  in  2  00 single-cycle, 01 MUL, 10 DIV, 11 REM
flush  in  1  pipeline flush; kills any op in EX
unit_done  in  1  unit completion strobe (VAR_LAT=1 only)
stall  out  1  hold IF/ID/EX (combinational)
unit_start  out  1  one-cycle start pulse to the unit (registered)
unit_rstn  out  1  active-low unit reset; low when idle (registered)
busy_class  out  2  class of the in-flight op; 00 when idle (registered)
result_valid  out  1  unit result may be written back this cycle
timeout_err  out  1  one-cycle pulse; variable-mode watchdog expired

Behaviour:
- Reset (resetn low, async): state=IDLE, cnt=0, unit_start=0, unit_rstn=0, busy_class=00, result_valid=0, timeout_err=0, stall=0.
- "long" means op_valid and op_class != 00.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = long & ~flush.
  - If long & ~flush at the edge: go to BUSY, latch busy_class=op_class, and load cnt with LAT_<class>-1 (fixed mode) or TIMEOUT-1 (variable mode).
  - Otherwise stay in IDLE.
- BUSY:
  - stall=1. Outputs unit_rstn=1 and busy_class held.
  - unit_start=1 only in the first BUSY cycle.
  - Fixed mode: decrement cnt each cycle; at cnt==0 go to DONE. BUSY therefore lasts exactly LAT cycles.
  - Variable mode: unit_done=1 at the edge goes to DONE. Otherwise, at cnt==0 go to DONE and pulse timeout_err in the DONE cycle. Otherwise decrement.
- DONE:
  - stall=0, result_valid=~flush, unit_rstn=1.
  - Go to IDLE unconditionally.
  - New op acceptance is inhibited here. The same instruction is still in EX and advances at this edge, so it must not retrigger.
- Timing, fixed mode with op first seen in cycle 0: stall is high in cycles 0..LAT, result_valid is high in cycle LAT+1, and the next long op can be accepted in cycle LAT+2. Back-to-back long ops lose no cycle beyond this.
- Flush:
  - In BUSY: go to IDLE next; unit_rstn drops next cycle; no result_valid, no timeout_err.
  - In DONE: result_valid is suppressed.
  - Flush outranks unit_done and counter expiry in the same cycle.
- unit_done outside BUSY, or when VAR_LAT=0, is ignored.
- op_class changing during BUSY is ignored; busy_class is latched.
- Counter width is CW = $clog2(max(LAT_MUL, LAT_DIV, LAT_REM, TIMEOUT)+1). Decrement never underflows.
- Illegal parameters (any LAT_* <1; TIMEOUT<2 or TIMEOUT<=max LAT_* when VAR_LAT=1) are caught by an elaboration-time check.

Decomposition:
- Shared package: op_class encodings (CLS_NONE, CLS_MUL, CLS_DIV, CLS_REM), state encoding, and a max-latency function used for CW.
- One sub-module: mc_down_counter (load value, load enable, decrement enable, zero flag, parametrised width), used for both latency and timeout.

Test Plan:
- Fixed mode, DIV (LAT_DIV=9) held valid from cycle 0: stall high cycles 0-9; unit_start high in cycle 1 only; unit_rstn high cycles 1-10; result_valid high in cycle 10 only; no retrigger in cycle 11.
- Back-to-back MUL then DIV: MUL result_valid in cycle 3; DIV accepted in cycle 4; DIV result_valid in cycle 14; busy_class reads 01 then 10.
- Flush in cycle 5 of a DIV: state returns to IDLE in cycle 6; unit_rstn=0 in cycle 6; result_valid never asserted; stall low from cycle 6.
- VAR_LAT=1, unit_done pulsed in cycle 4: result_valid in cycle 5, timeout_err=0. Second op with no unit_done and TIMEOUT=64: result_valid and timeout_err both high in cycle 65.
- Async resetn asserted mid-BUSY (cycle 3), not aligned to a clock edge: all outputs go to reset values immediately; after release, a REM op starts cleanly with a full LAT_REM.
- Single-cycle op (class 00) and flush together with a long op in IDLE: stall stays 0, unit_start stays 0, no state change.
